piso_tx: RTL and testbench

PISO_TX -- requirements
Module: piso_tx

---
 rtl/piso_tx.sv | 159 +++++++++++++++
 tb/tb_piso_tx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with a single-entry skid buffer.
//
// A word is accepted when pi_valid and pi_ready are both high on a rising
// edge. While a word is being shifted out, one further word can be parked in
// the holding buffer so that consecutive words stream with no idle cycles.
//
// Parameters:
//   WIDTH      bits per parallel word (2..32)
//   LSB_FIRST  0: MSB leaves first, 1: LSB leaves first
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   pi_data      parallel word offered for transmission
//   pi_valid     pi_data is valid this cycle
//   pi_ready     a word can be accepted this cycle (depends on state only)
//   so           serial data bit
//   so_valid     so carries a valid bit this cycle
//   frame_start  high during the first bit of each word
//   done         high during the last bit of each word
module piso_tx #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pi_data,
    input  logic             pi_valid,
    output logic             pi_ready,
    output logic             so,
    output logic             so_valid,
    output logic             frame_start,
    output logic             done
);

    localparam int unsigned      CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [WIDTH-1:0]  buf_data_q, buf_data_d;
    logic              buf_full_q, buf_full_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic              accept;
    logic              last_bit;
    logic [WIDTH-1:0]  shift_adv;

    // Ready is taken from the buffer flag alone, so there is no path from
    // pi_valid back to pi_ready.
    assign pi_ready = ~buf_full_q;
    assign accept   = pi_valid & pi_ready;
    assign last_bit = (state_q == StShift) && (cnt_q == LastCnt);

    // The bit on so always sits at the outgoing end of the shift register.
    assign shift_adv = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                // Stay in SHIFT when a follow-on word is buffered or arrives
                // exactly on the last-bit edge.
                if (last_bit && !buf_full_q && !accept) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q    <= '0;
            buf_data_q <= '0;
            buf_full_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            shift_q    <= shift_d;
            buf_data_q <= buf_data_d;
            buf_full_q <= buf_full_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        shift_d    = shift_q;
        buf_data_d = buf_data_q;
        buf_full_d = buf_full_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            StIdle: begin
                // From idle the word bypasses the buffer.
                if (accept) begin
                    shift_d = pi_data;
                    cnt_d   = '0;
                end
            end
            StShift: begin
                shift_d = shift_adv;
                if (last_bit) begin
                    cnt_d = '0;
                    if (buf_full_q) begin
                        shift_d    = buf_data_q;
                        buf_full_d = 1'b0;
                    end else if (accept) begin
                        shift_d = pi_data;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                    if (accept) begin
                        buf_data_d = pi_data;
                        buf_full_d = 1'b1;
                    end
                end
            end
            default: begin
                shift_d    = '0;
                buf_full_d = 1'b0;
                cnt_d      = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs: all serial-side outputs are forced low outside SHIFT.
    // ---------------------------------------------------------------------
    always_comb begin
        so_valid    = (state_q == StShift);
        so          = so_valid & (LSB_FIRST ? shift_q[0] : shift_q[WIDTH-1]);
        frame_start = so_valid & (cnt_q == '0);
        done        = so_valid & (cnt_q == LastCnt);
    end

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: one MSB-first and one LSB-first instance
// driven by the same stimulus. A scoreboard queues every accepted word and a
// serial-to-parallel monitor per instance rebuilds the words and compares.
module tb_piso_tx;

    localparam int unsigned W = 4;

    logic         clk      = 1'b0;
    logic         rst      = 1'b1;
    logic [W-1:0] pi_data  = '0;
    logic         pi_valid = 1'b0;

    logic rdy_m, so_m, sv_m, fs_m, dn_m;
    logic rdy_l, so_l, sv_l, fs_l, dn_l;

    piso_tx #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
        .clk         (clk),
        .rst         (rst),
        .pi_data     (pi_data),
        .pi_valid    (pi_valid),
        .pi_ready    (rdy_m),
        .so          (so_m),
        .so_valid    (sv_m),
        .frame_start (fs_m),
        .done        (dn_m)
    );

    piso_tx #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
        .clk         (clk),
        .rst         (rst),
        .pi_data     (pi_data),
        .pi_valid    (pi_valid),
        .pi_ready    (rdy_l),
        .so          (so_l),
        .so_valid    (sv_l),
        .frame_start (fs_l),
        .done        (dn_l)
    );

    always #5 clk = ~clk;

    int unsigned  n_checks = 0;
    int unsigned  n_errors = 0;
    logic [W-1:0] q_m[$];
    logic [W-1:0] q_l[$];
    logic [W-1:0] acc_m = '0;
    logic [W-1:0] acc_l = '0;
    logic [W-1:0] last_rx_m = '0;
    int unsigned  idx_m = 0;
    int unsigned  idx_l = 0;
    int unsigned  rx_cnt = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboard push: values read at the edge are the pre-edge values.
    initial forever begin
        @(posedge clk);
        if (rst && pi_valid && rdy_m) q_m.push_back(pi_data);
        if (rst && pi_valid && rdy_l) q_l.push_back(pi_data);
    end

    task automatic mon_m();
        logic [W-1:0] exp;
        if (sv_m) begin
            check("fs_m", 32'(fs_m), 32'(idx_m == 0));
            check("done_m", 32'(dn_m), 32'(idx_m == W - 1));
            acc_m = {acc_m[W-2:0], so_m};
            if (idx_m == W - 1) begin
                check("sb_m_nonempty", 32'(q_m.size() != 0), 32'd1);
                if (q_m.size() != 0) begin
                    exp = q_m.pop_front();
                    check("word_m", 32'(acc_m), 32'(exp));
                end
                last_rx_m = acc_m;
                rx_cnt++;
                idx_m = 0;
            end else begin
                idx_m++;
            end
        end else begin
            check("idle_m", 32'({so_m, fs_m, dn_m}), 32'd0);
            check("gap_m", idx_m, 32'd0);
        end
    endtask

    task automatic mon_l();
        logic [W-1:0] exp;
        if (sv_l) begin
            check("fs_l", 32'(fs_l), 32'(idx_l == 0));
            check("done_l", 32'(dn_l), 32'(idx_l == W - 1));
            acc_l = {so_l, acc_l[W-1:1]};
            if (idx_l == W - 1) begin
                check("sb_l_nonempty", 32'(q_l.size() != 0), 32'd1);
                if (q_l.size() != 0) begin
                    exp = q_l.pop_front();
                    check("word_l", 32'(acc_l), 32'(exp));
                end
                idx_l = 0;
            end else begin
                idx_l++;
            end
        end else begin
            check("idle_l", 32'({so_l, fs_l, dn_l}), 32'd0);
            check("gap_l", idx_l, 32'd0);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            idx_m = 0;
            idx_l = 0;
            check("rst_ready", 32'({rdy_m, rdy_l}), 32'b11);
            check("rst_outs", 32'({so_m, sv_m, fs_m, dn_m, so_l, sv_l, fs_l, dn_l}), 32'd0);
        end else begin
            mon_m();
            mon_l();
        end
    end

    initial begin
        logic [W-1:0] w;
        logic [7:0]   stream;
        int unsigned  rx0;
        int unsigned  waited;
        int unsigned  drain;
        logic         took;

        // Reset applied with no clock edge in between.
        #1 rst = 1'b0;
        #2;
        check("rst_async_ready", 32'(rdy_m), 32'd1);
        check("rst_async_sv", 32'({sv_m, sv_l, so_m, so_l}), 32'd0);

        // Single word from idle, accepted on the first edge after release.
        @(negedge clk);
        #1 rst = 1'b1;
        w = 4'b1011;
        pi_valid = 1'b1;
        pi_data  = w;
        @(posedge clk);
        #1 pi_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t1_sv", 32'({sv_m, sv_l}), 32'b11);
            check("t1_so_msb", 32'(so_m), 32'(w[3-i]));
            check("t1_so_lsb", 32'(so_l), 32'(w[i]));
            check("t1_fs", 32'(fs_m), 32'(i == 0));
            check("t1_done", 32'(dn_m), 32'(i == 3));
        end
        @(negedge clk);
        check("t1_idle", 32'({sv_m, sv_l}), 32'd0);

        // Back-to-back words with no gap.
        @(posedge clk);
        #1;
        stream   = 8'b1100_0110;
        pi_valid = 1'b1;
        pi_data  = 4'b1100;
        @(posedge clk);
        #1 pi_data = 4'b0110;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("b2b_sv", 32'(sv_m), 32'd1);
            check("b2b_so", 32'(so_m), 32'(stream[7-i]));
            check("b2b_ready", 32'(rdy_m), 32'((i == 0) || (i >= 4)));
            if (i == 0) begin
                @(posedge clk);
                #1 pi_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_idle", 32'(sv_m), 32'd0);

        // Reset mid-word with a buffered word.
        @(posedge clk);
        #1;
        pi_valid = 1'b1;
        pi_data  = 4'b1111;
        @(posedge clk);
        #1 pi_data = 4'b0101;
        @(posedge clk);
        #1 pi_valid = 1'b0;
        @(negedge clk);
        check("r_buffered", 32'(rdy_m), 32'd0);
        check("r_bit2_sv", 32'(sv_m), 32'd1);
        #1 rst = 1'b0;
        q_m.delete();
        q_l.delete();
        #1;
        check("r_async_sv", 32'({sv_m, sv_l, so_m, so_l}), 32'd0);
        check("r_async_ready", 32'({rdy_m, rdy_l}), 32'b11);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("r_quiet", 32'({sv_m, sv_l}), 32'd0);
        end

        // pi_data sampled only on the accepting edge.
        @(posedge clk);
        #1;
        rx0      = rx_cnt;
        pi_valid = 1'b1;
        pi_data  = 4'b0011;
        @(posedge clk);
        #1 pi_data = 4'b1001;
        @(posedge clk);
        #1 pi_data = 4'b1010;
        @(negedge clk);
        check("hold_blocked", 32'(rdy_m), 32'd0);
        @(posedge clk);
        #1 pi_data = 4'b0110;
        @(posedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("hold_free", 32'(rdy_m), 32'd1);
        @(posedge clk);
        #1;
        pi_valid = 1'b0;
        pi_data  = 4'b1111;
        repeat (14) @(negedge clk);
        check("hold_count", rx_cnt - rx0, 32'd3);
        check("hold_word", 32'(last_rx_m), 32'b0110);

        // Random words with random gaps and data churn while stalled.
        @(posedge clk);
        #1;
        rx0 = rx_cnt;
        for (int n = 0; n < 100; n++) begin
            pi_valid = 1'b0;
            pi_data  = W'($urandom);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            pi_data  = W'($urandom);
            pi_valid = 1'b1;
            waited   = 0;
            took     = 1'b0;
            while (!took && waited < 50) begin
                @(negedge clk);
                took = rdy_m;
                @(posedge clk);
                #1;
                if (!took) begin
                    waited++;
                    pi_data = W'($urandom);
                end
            end
            check("rnd_accept", 32'(took), 32'd1);
        end
        pi_valid = 1'b0;
        drain = 0;
        while ((q_m.size() != 0 || q_l.size() != 0) && drain < 100) begin
            @(negedge clk);
            drain++;
        end
        @(negedge clk);
        check("rnd_drain", q_m.size() + q_l.size(), 32'd0);
        check("rnd_count", rx_cnt - rx0, 32'd100);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
